// File: rtl/ctrl_pkg.sv
// Shared definitions for the dispatch stall controller: FSM state encoding
// and default parameter values.
package ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALL   = 2'd1,
    RECOVER = 2'd2
  } ctrl_state_e;

  localparam int NUM_RES_DEF        = 4;
  localparam int CNT_W_DEF          = 6;
  localparam int DISPATCH_WIDTH_DEF = 2;
  localparam int FLUSH_CYCLES_DEF   = 2;
  localparam int PERF_W_DEF         = 32;
  localparam int REC_W              = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] cnt_r;
  logic             at_max_s;

  assign at_max_s = &cnt_r;

  // count register: hold at all-ones instead of wrapping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (clr) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (inc && !at_max_s) begin
      cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/stall_controller.sv
// Front-end stall controller: holds fetch/dispatch when any enabled back-end
// resource is short of entries, with a fixed recovery window after a flush.
module stall_controller
  import ctrl_pkg::*;
#(
  parameter int NUM_RES        = NUM_RES_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  parameter int DISPATCH_WIDTH = DISPATCH_WIDTH_DEF,
  parameter int FLUSH_CYCLES   = FLUSH_CYCLES_DEF,
  parameter int PERF_W         = PERF_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_RES*CNT_W-1:0]  res_free_cnt,
  input  logic [NUM_RES-1:0]        res_en,
  input  logic                      perf_clr,
  output logic                      stall_fetch,
  output logic                      stall_dispatch,
  output logic [1:0]                state_o,
  output logic [NUM_RES-1:0]        stall_cause,
  output logic [NUM_RES*PERF_W-1:0] perf_stall_cnt,
  output logic [PERF_W-1:0]         perf_flush_cnt
);

  localparam logic [1:0]       S_RUN      = RUN;
  localparam logic [1:0]       S_STALL    = STALL;
  localparam logic [1:0]       S_RECOVER  = RECOVER;
  localparam logic [CNT_W-1:0] DW_C       = CNT_W'(DISPATCH_WIDTH);
  localparam logic [REC_W-1:0] REC_LOAD_C = REC_W'(FLUSH_CYCLES - 1);

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [REC_W-1:0]   rec_r;
  logic [REC_W-1:0]   rec_nxt_s;
  logic [NUM_RES-1:0] short_s;
  logic               any_short_s;
  logic [NUM_RES-1:0] cause_r;
  logic               fetch_r;
  logic               dispatch_r;
  logic [NUM_RES-1:0] stall_inc_s;

  // per-channel shortage: enabled and fewer free entries than one dispatch group
  always_comb begin
    short_s = {NUM_RES{1'b0}};
    for (int i = 0; i < NUM_RES; i++) begin
      if (res_en[i] && (res_free_cnt[i*CNT_W +: CNT_W] < DW_C)) begin
        short_s[i] = 1'b1;
      end else begin
        short_s[i] = 1'b0;
      end
    end
  end

  assign any_short_s = |short_s;

  // next-state logic; flush overrides everything and restarts recovery
  always_comb begin
    state_nxt_s = state_r;
    rec_nxt_s   = rec_r;
    if (flush) begin
      state_nxt_s = S_RECOVER;
      rec_nxt_s   = REC_LOAD_C;
    end else begin
      case (state_r)
        S_RUN:   state_nxt_s = any_short_s ? S_STALL : S_RUN;
        S_STALL: state_nxt_s = any_short_s ? S_STALL : S_RUN;
        S_RECOVER: begin
          if (rec_r == {REC_W{1'b0}}) begin
            state_nxt_s = any_short_s ? S_STALL : S_RUN;
          end else begin
            rec_nxt_s = rec_r - {{(REC_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_nxt_s = S_RUN;
          rec_nxt_s   = {REC_W{1'b0}};
        end
      endcase
    end
  end

  // state and registered Moore outputs, decoded from the next state so they
  // always match the state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_RUN;
      rec_r      <= {REC_W{1'b0}};
      cause_r    <= {NUM_RES{1'b0}};
      fetch_r    <= 1'b0;
      dispatch_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      rec_r      <= rec_nxt_s;
      cause_r    <= flush ? {NUM_RES{1'b0}} : short_s;
      fetch_r    <= (state_nxt_s == S_STALL);
      dispatch_r <= (state_nxt_s != S_RUN);
    end
  end

  for (genvar gi = 0; gi < NUM_RES; gi++) begin : g_stall_cnt
    assign stall_inc_s[gi] = (state_r == S_STALL) && cause_r[gi];

    sat_counter #(.WIDTH(PERF_W)) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall_inc_s[gi]),
      .clr (perf_clr),
      .cnt (perf_stall_cnt[gi*PERF_W +: PERF_W])
    );
  end

  sat_counter #(.WIDTH(PERF_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush),
    .clr (perf_clr),
    .cnt (perf_flush_cnt)
  );

  assign stall_fetch    = fetch_r;
  assign stall_dispatch = dispatch_r;
  assign state_o        = state_r;
  assign stall_cause    = cause_r;

endmodule

// File: tb/tb_stall_controller.sv
// Directed bench for stall_controller with a cycle-level reference model and
// hand-computed literal checkpoints.
module tb_stall_controller;

  localparam int NR   = 4;
  localparam int CW   = 6;
  localparam int DW   = 2;
  localparam int FC   = 2;
  localparam int PW   = 4;
  localparam int PMAX = (1 << PW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              perf_clr;
  logic [NR-1:0]     res_en;
  logic [CW-1:0]     free [NR];
  logic [NR*CW-1:0]  res_free_cnt;
  logic              stall_fetch;
  logic              stall_dispatch;
  logic [1:0]        state_o;
  logic [NR-1:0]     stall_cause;
  logic [NR*PW-1:0]  perf_stall_cnt;
  logic [PW-1:0]     perf_flush_cnt;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_on = 1'b0;

  // reference model: 0=RUN 1=STALL 2=RECOVER
  int            m_state;
  int            m_rec;
  int            m_flush;
  int            m_perf [NR];
  logic [NR-1:0] m_cause;

  always #5 clk = ~clk;

  always_comb begin
    res_free_cnt = '0;
    for (int i = 0; i < NR; i++) res_free_cnt[i*CW +: CW] = free[i];
  end

  stall_controller #(
    .NUM_RES(NR), .CNT_W(CW), .DISPATCH_WIDTH(DW), .FLUSH_CYCLES(FC), .PERF_W(PW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .res_free_cnt   (res_free_cnt),
    .res_en         (res_en),
    .perf_clr       (perf_clr),
    .stall_fetch    (stall_fetch),
    .stall_dispatch (stall_dispatch),
    .state_o        (state_o),
    .stall_cause    (stall_cause),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NR-1:0] short_vec();
    logic [NR-1:0] v;
    v = '0;
    for (int i = 0; i < NR; i++) v[i] = res_en[i] && (int'(free[i]) < DW);
    return v;
  endfunction

  function automatic logic [31:0] perf_of(input int ch);
    return 32'(perf_stall_cnt[ch*PW +: PW]);
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_rec   = 0;
    m_flush = 0;
    m_cause = '0;
    for (int i = 0; i < NR; i++) m_perf[i] = 0;
  endtask

  // one clock edge of behaviour, computed from the inputs present at the edge
  task automatic model_step();
    logic [NR-1:0] sv;
    sv = short_vec();
    if (perf_clr) begin
      for (int i = 0; i < NR; i++) m_perf[i] = 0;
      m_flush = 0;
    end else begin
      for (int i = 0; i < NR; i++)
        if (m_state == 1 && m_cause[i] && m_perf[i] < PMAX) m_perf[i]++;
      if (flush && m_flush < PMAX) m_flush++;
    end
    if (flush) begin
      m_state = 2;
      m_rec   = FC - 1;
    end else if (m_state == 2 && m_rec > 0) begin
      m_rec--;
    end else begin
      m_state = (sv != '0) ? 1 : 0;
    end
    m_cause = flush ? '0 : sv;
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      if (rst) model_reset();
      else     model_step();
      @(negedge clk);
      #1;
    end
  endtask

  // compare every DUT output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      check("stall_fetch",    32'(stall_fetch),    32'(m_state == 1));
      check("stall_dispatch", 32'(stall_dispatch), 32'(m_state != 0));
      check("state_o",        32'(state_o),        32'(m_state));
      check("stall_cause",    32'(stall_cause),    32'(m_cause));
      for (int i = 0; i < NR; i++) check("perf_stall_cnt", perf_of(i), 32'(m_perf[i]));
      check("perf_flush_cnt", 32'(perf_flush_cnt), 32'(m_flush));
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; perf_clr = 1'b0; res_en = 4'hF;
    for (int i = 0; i < NR; i++) free[i] = 6'd10;
    model_reset();
    #2;
    check("rst_fetch",    32'(stall_fetch),    32'd0);
    check("rst_dispatch", 32'(stall_dispatch), 32'd0);
    check("rst_state",    32'(state_o),        32'd0);
    check("rst_cause",    32'(stall_cause),    32'd0);
    check("rst_flushcnt", 32'(perf_flush_cnt), 32'd0);
    @(negedge clk); #1;
    chk_on = 1'b1;
    rst = 1'b0;

    // all resources plentiful
    cyc(6);
    check("idle_state", 32'(state_o), 32'd0);
    check("idle_perf1", perf_of(1), 32'd0);

    // channel 1 short for four cycles
    free[1] = 6'd1; cyc(1);
    check("s1_fetch", 32'(stall_fetch), 32'd1);
    check("s1_disp",  32'(stall_dispatch), 32'd1);
    check("s1_cause", 32'(stall_cause), 32'b0010);
    cyc(3);
    free[1] = 6'd8; cyc(1);
    check("s1_perf1", perf_of(1), 32'd4);
    check("s1_end_state", 32'(state_o), 32'd0);

    // flush during STALL
    free[1] = 6'd1; cyc(1);
    flush = 1'b1; cyc(1); flush = 1'b0;
    check("fl_state",    32'(state_o), 32'd2);
    check("fl_fetch",    32'(stall_fetch), 32'd0);
    check("fl_disp",     32'(stall_dispatch), 32'd1);
    check("fl_cause",    32'(stall_cause), 32'd0);
    check("fl_flushcnt", 32'(perf_flush_cnt), 32'd1);
    cyc(1);
    check("fl_state2", 32'(state_o), 32'd2);
    cyc(1);
    check("fl_exit_stall", 32'(state_o), 32'd1);

    // second flush in the final recovery cycle
    free[1] = 6'd8; perf_clr = 1'b1; cyc(1); perf_clr = 1'b0;
    check("clr_perf1", perf_of(1), 32'd0);
    check("clr_flush", 32'(perf_flush_cnt), 32'd0);
    flush = 1'b1; cyc(1); flush = 1'b0;
    cyc(1);
    flush = 1'b1; cyc(1); flush = 1'b0;
    check("fl2_state_a", 32'(state_o), 32'd2);
    cyc(1);
    check("fl2_state_b", 32'(state_o), 32'd2);
    cyc(1);
    check("fl2_exit_run", 32'(state_o), 32'd0);
    check("fl2_flushcnt", 32'(perf_flush_cnt), 32'd2);

    // disabled channel never stalls
    res_en = 4'b1110; free[0] = 6'd0; cyc(3);
    check("dis_state", 32'(state_o), 32'd0);
    res_en = 4'hF; cyc(1);
    check("en_cause", 32'(stall_cause), 32'b0001);
    free[0] = 6'd10; cyc(1);

    // threshold boundary and multi-channel cause
    free[3] = 6'd2; cyc(1);
    check("bnd_eq_run", 32'(state_o), 32'd0);
    free[3] = 6'd1; free[2] = 6'd0; cyc(1);
    check("bnd_cause", 32'(stall_cause), 32'b1100);
    free[3] = 6'd10; free[2] = 6'd10; cyc(1);

    // saturation, then clear coincident with a stall cycle
    perf_clr = 1'b1; cyc(1); perf_clr = 1'b0;
    free[2] = 6'd0; cyc(21);
    check("sat_perf2", perf_of(2), 32'd15);
    perf_clr = 1'b1; cyc(1); perf_clr = 1'b0;
    check("clr_wins", perf_of(2), 32'd0);
    cyc(1);
    check("post_clr", perf_of(2), 32'd1);

    // asynchronous reset mid-STALL
    #2; rst = 1'b1; model_reset(); #1;
    check("arst_fetch", 32'(stall_fetch), 32'd0);
    check("arst_state", 32'(state_o), 32'd0);
    check("arst_perf2", perf_of(2), 32'd0);
    cyc(2);
    free[2] = 6'd10; rst = 1'b0; cyc(1);
    check("arst_run", 32'(state_o), 32'd0);

    // asynchronous reset mid-RECOVER
    flush = 1'b1; cyc(1); flush = 1'b0;
    #2; rst = 1'b1; model_reset(); #1;
    check("arst2_disp",  32'(stall_dispatch), 32'd0);
    check("arst2_flush", 32'(perf_flush_cnt), 32'd0);
    cyc(1);
    rst = 1'b0; cyc(1);
    check("arst2_run", 32'(state_o), 32'd0);
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/stall_controller.md
STALL_CONTROLLER -- requirements
Module: stall_controller

Interface
REQ-001 Parameter NUM_RES, default 4: number of tracked back-end resources (channel 0 ROB, 1 free list, 2 issue queue, 3 LSQ).
REQ-002 Parameter CNT_W, default 6: width of each free-entry count.
REQ-003 Parameter DISPATCH_WIDTH, default 2: entries needed per resource per dispatch cycle; value SHALL be less than 2**CNT_W.
REQ-004 Parameter FLUSH_CYCLES, default 2: recovery cycles after a flush, range 1..15.
REQ-005 Parameter PERF_W, default 32: performance counter width.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 flush  input  1  pipeline redirect (mispredict or exception), one-cycle pulse per event.
REQ-009 res_free_cnt  input  NUM_RES*CNT_W  free entries per channel; channel i at bits [i*CNT_W +: CNT_W].
REQ-010 res_en  input  NUM_RES  channel enable mask; a disabled channel never causes a stall.
REQ-011 perf_clr  input  1  synchronous clear of all performance counters.
REQ-012 stall_fetch  output  1  hold the fetch stage.
REQ-013 stall_dispatch  output  1  hold the dispatch stage.
REQ-014 state_o  output  2  current FSM state, encoded as ctrl_state_e.
REQ-015 stall_cause  output  NUM_RES  registered per-channel stall reasons.
REQ-016 perf_stall_cnt  output  NUM_RES*PERF_W  per-channel count of stall cycles.
REQ-017 perf_flush_cnt  output  PERF_W  count of accepted flushes.

Function
REQ-018 Channel i SHALL be short when res_en[i]=1 and res_free_cnt[i] < DISPATCH_WIDTH, using an unsigned compare at CNT_W bits; any_short is the OR over all channels.
REQ-019 The FSM SHALL have exactly three states: RUN, STALL and RECOVER.
REQ-020 Transition priority SHALL be flush first, then the rules in REQ-021 to REQ-023.
REQ-021 From RUN: go to STALL if any_short, otherwise stay in RUN.
REQ-022 From STALL: go to RUN when any_short=0, otherwise stay in STALL.
REQ-023 From RECOVER: when the recovery counter is 0, go to STALL if any_short, else RUN; otherwise decrement the counter.
REQ-024 A flush in any state SHALL enter RECOVER and load the recovery counter with FLUSH_CYCLES-1; a flush arriving in RECOVER restarts the count.
REQ-025 Outputs SHALL be a Moore decode of the state register: RUN gives stall_fetch=0, stall_dispatch=0; STALL gives 1/1; RECOVER gives 0/1.
REQ-026 Latency from an input change to the outputs SHALL be exactly one clock edge; there is no combinational path from any input to any output.
REQ-027 stall_cause SHALL register the per-channel short vector every cycle, and SHALL be forced to 0 on a cycle that enters RECOVER.
REQ-028 perf_stall_cnt[i] SHALL increment by one on each cycle where the state is STALL and stall_cause[i]=1.
REQ-029 perf_flush_cnt SHALL increment by one on each cycle where flush=1.
REQ-030 All counters SHALL saturate at 2**PERF_W-1 and never wrap.
REQ-031 perf_clr SHALL zero all counters on the next edge and wins over a simultaneous increment.

Reset
REQ-032 rst SHALL force, immediately and asynchronously: state=RUN, recovery counter=0, stall_cause=0, all performance counters=0, stall_fetch=0, stall_dispatch=0.
REQ-033 A reset asserted mid-STALL or mid-RECOVER SHALL discard all progress; the block leaves reset in RUN on the first edge after rst deasserts.

Structure
REQ-034 A shared package ctrl_pkg SHALL hold the enum ctrl_state_e (RUN=0, STALL=1, RECOVER=2) and the default parameter constants.
REQ-035 Saturating counters SHALL be one sub-module, sat_counter (parameter WIDTH; inputs inc and clr), instantiated NUM_RES+1 times.

Verification
REQ-036 Scenario: all free counts =10, res_en=4'hF -> outputs stay 0/0 and the counters stay 0 indefinitely.
REQ-037 Scenario: channel 1 count drops to 1 at cycle 5 and returns to 8 at cycle 9 -> stall_fetch and stall_dispatch are 1 for cycles 6-9, perf_stall_cnt[1]=4, stall_cause=4'b0010 during the stall.
REQ-038 Scenario: flush pulse during STALL with FLUSH_CYCLES=2 -> RECOVER for 2 cycles with outputs 0/1, stall_cause=0, then RUN or STALL according to the counts; perf_flush_cnt=1.
REQ-039 Scenario: a second flush in the final RECOVER cycle -> RECOVER extends by 2 more cycles; perf_flush_cnt=2.
REQ-040 Scenario: res_en=4'b1110 with channel 0 count =0 -> no stall occurs.
REQ-041 Scenario: PERF_W=4 with 20 stall cycles -> the counter holds at 15; perf_clr coincident with a stall cycle -> the counter reads 0.
